memory_compression_buf: RTL and testbench

MEMORY_COMPRESSION_BUF -- requirements
Module: memory_compression_buf

---
 rtl/memory_compression_pkg.sv | 5 +
 rtl/memory_compression_codec.sv | 29 ++
 rtl/memory_compression_buf.sv | 83 ++++++++
 tb/tb_memory_compression_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_compression_pkg.sv
// memory_compression_pkg: shared mode encoding and clear-FSM state type
package memory_compression_pkg;
  typedef enum logic {COMP_MODE_TRUNC = 1'b0, COMP_MODE_NARROW = 1'b1} comp_mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;
endpackage

// File: rtl/memory_compression_codec.sv
// memory_compression_codec: combinational encode (data_i, mode_i -> enc_o, lossy_o) and decode (pay_i, tag_i -> dec_o)
module memory_compression_codec
  import memory_compression_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COMP_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              mode_i,
  output logic [COMP_W-1:0] enc_o,
  output logic              lossy_o,
  input  logic [COMP_W-1:0] pay_i,
  input  logic              tag_i,
  output logic [DATA_W-1:0] dec_o
);
  localparam int PAD = DATA_W - COMP_W;
  logic [COMP_W:0]   sum;
  logic [COMP_W-1:0] trunc_pay, narrow_pay;
  logic [DATA_W-1:0] enc_dec;
  logic              fits;
  assign sum        = {1'b0, data_i[DATA_W-1 -: COMP_W]} + {{COMP_W{1'b0}}, data_i[PAD-1]};
  assign trunc_pay  = sum[COMP_W] ? '1 : sum[COMP_W-1:0];
  assign fits       = &data_i[DATA_W-1:COMP_W-1] | ~|data_i[DATA_W-1:COMP_W-1];
  assign narrow_pay = fits ? data_i[COMP_W-1:0] : {data_i[DATA_W-1], {(COMP_W-1){~data_i[DATA_W-1]}}};
  assign enc_o      = (mode_i == COMP_MODE_NARROW) ? narrow_pay : trunc_pay;
  assign enc_dec    = (mode_i == COMP_MODE_NARROW) ? {{PAD{enc_o[COMP_W-1]}}, enc_o} : {enc_o, {PAD{1'b0}}};
  assign lossy_o    = enc_dec != data_i;
  assign dec_o      = (tag_i == COMP_MODE_NARROW) ? {{PAD{pay_i[COMP_W-1]}}, pay_i} : {pay_i, {PAD{1'b0}}};
endmodule

// File: rtl/memory_compression_buf.sv
// memory_compression_buf: compressed word store; wr_* write port, 2-cycle pipelined rd_* read port, clr sweep (busy), saturating lossy_cnt
module memory_compression_buf
  import memory_compression_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COMP_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_mode,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              clr,
  output logic              busy,
  output logic [15:0]       lossy_cnt
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [COMP_W-1:0] pay_mem [DEPTH];
  logic [DEPTH-1:0]  tag_mem, valid_q;
  logic              s1_valid_q, s1_ent_q, s1_tag_q;
  logic [COMP_W-1:0] s1_pay_q, enc;
  logic [DATA_W-1:0] rd_data_q, dec;
  logic              rd_data_valid_q, lossy, wr_acc, rd_acc, sweep_done;
  logic [15:0]       lossy_q;
  assign busy          = state_q == ST_CLEAR;
  assign wr_ready      = ~busy;
  assign rd_ready      = ~busy;
  assign wr_acc        = wr_valid & wr_ready;
  assign rd_acc        = rd_valid & rd_ready;
  assign sweep_done    = busy && clr_idx_q == ADDR_W'(DEPTH - 1);
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign lossy_cnt     = lossy_q;
  always_comb begin
    state_d = state_q;
    if (!busy && clr) state_d = ST_CLEAR;
    else if (sweep_done) state_d = ST_IDLE;
  end
  memory_compression_codec #(.DATA_W(DATA_W), .COMP_W(COMP_W)) u_codec (
    .data_i(wr_data), .mode_i(wr_mode), .enc_o(enc), .lossy_o(lossy),
    .pay_i(s1_pay_q), .tag_i(s1_tag_q), .dec_o(dec)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      clr_idx_q       <= '0;
      valid_q         <= '0;
      lossy_q         <= '0;
      s1_valid_q      <= 1'b0;
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= busy ? clr_idx_q + 1'b1 : '0;
      if (busy) valid_q[clr_idx_q] <= 1'b0;
      if (wr_acc) valid_q[wr_addr] <= 1'b1;
      if (sweep_done) lossy_q <= '0;
      else if (wr_acc && lossy && lossy_q != 16'hFFFF) lossy_q <= lossy_q + 1'b1;
      s1_valid_q      <= rd_acc;
      rd_data_valid_q <= s1_valid_q;
      if (s1_valid_q) rd_data_q <= s1_ent_q ? dec : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      pay_mem[wr_addr] <= enc;
      tag_mem[wr_addr] <= wr_mode;
    end
    s1_pay_q <= pay_mem[rd_addr];
    s1_tag_q <= tag_mem[rd_addr];
    s1_ent_q <= valid_q[rd_addr];
  end
endmodule

// File: tb/tb_memory_compression_buf.sv
// tb_memory_compression_buf: randomized and directed checks of memory_compression_buf against a behavioural model
module tb_memory_compression_buf;
  logic        clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, wr_mode = 1'b0, rd_valid = 1'b0, clr = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready, rd_ready, rd_data_valid, busy;
  logic [15:0] rd_data, lossy_cnt;
  int          total = 0, bad = 0;
  logic [15:0] m_mem [16];
  bit          m_val [16];
  int          m_lossy = 0;
  memory_compression_buf #(.DATA_W(16), .COMP_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mode(wr_mode), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .clr(clr),
    .busy(busy), .lossy_cnt(lossy_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  function automatic logic [15:0] model_dec(input logic [15:0] d, input logic m);
    int v;
    if (!m) begin
      v = (int'(d) + 128) / 256;
      if (v > 255) v = 255;
      return 16'(v * 256);
    end
    v = int'($signed(d));
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 16'(v);
  endfunction
  function automatic logic [15:0] model_read(input logic [3:0] a);
    return m_val[a] ? m_mem[a] : 16'h0000;
  endfunction
  task automatic model_write(input logic [3:0] a, input logic [15:0] d, input logic m);
    logic [15:0] e;
    e = model_dec(d, m);
    m_mem[a] = e;
    m_val[a] = 1'b1;
    if (e != d && m_lossy < 65535) m_lossy++;
  endtask
  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    m_lossy = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mode = m;
    step();
    wr_valid = 1'b0;
    model_write(a, d, m);
  endtask
  task automatic read_word(input logic [3:0] a, output logic [15:0] got, output int lat);
    rd_valid = 1'b1; rd_addr = a;
    step();
    rd_valid = 1'b0;
    lat = 1;
    while (rd_data_valid !== 1'b1 && lat < 5) begin
      step();
      lat++;
    end
    got = rd_data;
  endtask
  task automatic test_reset();
    logic [15:0] got;
    int lat;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_clear();
    step();
    total++; if ({busy, wr_ready, rd_ready} !== 3'b011) begin bad++; $display("FAIL reset_handshake got=%b want=011", {busy, wr_ready, rd_ready}); end
    total++; if (lossy_cnt !== 16'd0) begin bad++; $display("FAIL reset_lossy got=%h want=0000", lossy_cnt); end
    total++; if (rd_data !== 16'd0 || rd_data_valid !== 1'b0) begin bad++; $display("FAIL reset_rd got=%h/%b want=0000/0", rd_data, rd_data_valid); end
    read_word(4'd7, got, lat);
    total++; if (got !== model_read(4'd7) || lat != 2) begin bad++; $display("FAIL reset_read got=%h lat=%0d want=%h lat=2", got, lat, model_read(4'd7)); end
  endtask
  task automatic test_trunc();
    logic [15:0] d [3], want [3], got;
    int lat;
    d = '{16'h127F, 16'h1280, 16'hFF80};
    want = '{16'h1200, 16'h1300, 16'hFF00};
    for (int i = 0; i < 3; i++) do_write(4'(i + 1), d[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      read_word(4'(i + 1), got, lat);
      total++; if (got !== want[i] || got !== model_read(4'(i + 1)) || lat != 2) begin bad++; $display("FAIL trunc_read%0d got=%h lat=%0d want=%h lat=2", i, got, lat, want[i]); end
    end
    total++; if (lossy_cnt !== 16'd3 || lossy_cnt !== 16'(m_lossy)) begin bad++; $display("FAIL trunc_lossy got=%0d want=3", lossy_cnt); end
  endtask
  task automatic test_narrow();
    logic [15:0] d [4], want [4], got;
    int lat;
    d = '{16'h0045, 16'hFFB0, 16'h0200, 16'hFE00};
    want = '{16'h0045, 16'hFFB0, 16'h007F, 16'hFF80};
    for (int i = 0; i < 4; i++) do_write(4'(i + 8), d[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      read_word(4'(i + 8), got, lat);
      total++; if (got !== want[i] || got !== model_read(4'(i + 8)) || lat != 2) begin bad++; $display("FAIL narrow_read%0d got=%h lat=%0d want=%h lat=2", i, got, lat, want[i]); end
    end
    total++; if (lossy_cnt !== 16'd5 || lossy_cnt !== 16'(m_lossy)) begin bad++; $display("FAIL narrow_lossy got=%0d want=5", lossy_cnt); end
  endtask
  task automatic test_same_cycle();
    logic [15:0] got, exp;
    int lat;
    do_write(4'd5, 16'h0022, 1'b1);
    exp = model_read(4'd5);
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'h0011; wr_mode = 1'b1;
    rd_valid = 1'b1; rd_addr = 4'd5;
    step();
    wr_valid = 1'b0; rd_valid = 1'b0;
    model_write(4'd5, 16'h0011, 1'b1);
    lat = 1;
    while (rd_data_valid !== 1'b1 && lat < 5) begin
      step();
      lat++;
    end
    total++; if (rd_data !== 16'h0022 || rd_data !== exp || lat != 2) begin bad++; $display("FAIL same_cycle_old got=%h lat=%0d want=0022 lat=2", rd_data, lat); end
    read_word(4'd5, got, lat);
    total++; if (got !== 16'h0011 || got !== model_read(4'd5) || lat != 2) begin bad++; $display("FAIL same_cycle_new got=%h lat=%0d want=0011 lat=2", got, lat); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] got, lastd, p1d, p2d, newd, want;
    logic [7:0]  b;
    bit          p1v, p2v;
    int          lat, sel, n;
    read_word(4'd0, got, lat);
    total++; if (got !== model_read(4'd0) || lat != 2) begin bad++; $display("FAIL b2b_prime got=%h want=%h", got, model_read(4'd0)); end
    lastd = model_read(4'd0);
    p1v = 1'b0; p2v = 1'b0; p1d = '0; p2d = '0;
    n = 400;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      sel = $urandom_range(0, 2);
      wr_valid = 1'($urandom); wr_addr = 4'($urandom); wr_mode = 1'($urandom);
      rd_valid = 1'($urandom_range(0, 3) != 0); rd_addr = 4'($urandom);
      wr_data = sel == 0 ? 16'($urandom) : sel == 1 ? {{8{b[7]}}, b} : {b, 1'($urandom), 7'h7F};
      if (i >= n - 2) begin wr_valid = 1'b0; rd_valid = 1'b0; end
      newd = model_read(rd_addr);
      if (wr_valid) model_write(wr_addr, wr_data, wr_mode);
      p2v = p1v; p2d = p1d; p1v = rd_valid; p1d = newd;
      step();
      want = p2v ? p2d : lastd;
      lastd = want;
      total++; if (rd_data_valid !== p2v || rd_data !== want) begin bad++; $display("FAIL b2b_read cyc=%0d got=%h/%b want=%h/%b", i, rd_data, rd_data_valid, want, p2v); end
      total++; if (lossy_cnt !== 16'(m_lossy)) begin bad++; $display("FAIL b2b_lossy cyc=%0d got=%0d want=%0d", i, lossy_cnt, m_lossy); end
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask
  task automatic test_clear();
    logic [15:0] got, exp;
    int lat;
    do_write(4'd0, 16'h1234, 1'b1);
    exp = model_read(4'd0);
    clr = 1'b1; rd_valid = 1'b1; rd_addr = 4'd0;
    step();
    clr = 1'b0; rd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if ({busy, wr_ready, rd_ready} !== 3'b100) begin bad++; $display("FAIL clear_busy cyc=%0d got=%b want=100", i, {busy, wr_ready, rd_ready}); end
      if (i == 1) begin
        total++; if (rd_data_valid !== 1'b1 || rd_data !== exp) begin bad++; $display("FAIL clear_inflight got=%h/%b want=%h/1", rd_data, rd_data_valid, exp); end
      end else begin
        total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL clear_novalid cyc=%0d got=%b want=0", i, rd_data_valid); end
      end
      clr = i == 5; wr_valid = i == 5; rd_valid = i == 5;
      wr_addr = 4'd3; wr_data = 16'hABCD; rd_addr = 4'd0;
      step();
    end
    clr = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    model_clear();
    total++; if ({busy, wr_ready, rd_ready} !== 3'b011) begin bad++; $display("FAIL clear_done got=%b want=011", {busy, wr_ready, rd_ready}); end
    total++; if (lossy_cnt !== 16'(m_lossy)) begin bad++; $display("FAIL clear_lossy got=%0d want=0", lossy_cnt); end
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), got, lat);
      total++; if (got !== model_read(4'(a)) || lat != 2) begin bad++; $display("FAIL clear_read a=%0d got=%h lat=%0d want=0000", a, got, lat); end
    end
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 65534; i++) do_write(4'(i), 16'h0001, 1'b0);
    total++; if (lossy_cnt !== 16'hFFFE || lossy_cnt !== 16'(m_lossy)) begin bad++; $display("FAIL sat_fffe got=%h want=fffe", lossy_cnt); end
    do_write(4'd1, 16'h0001, 1'b0);
    total++; if (lossy_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h want=ffff", lossy_cnt); end
    for (int i = 0; i < 3; i++) do_write(4'(i), 16'h0001, 1'b0);
    total++; if (lossy_cnt !== 16'hFFFF || lossy_cnt !== 16'(m_lossy)) begin bad++; $display("FAIL sat_hold got=%h want=ffff", lossy_cnt); end
  endtask
  task automatic test_rst_inflight();
    logic [15:0] got;
    int lat;
    do_write(4'd2, 16'h0300, 1'b1);
    read_word(4'd2, got, lat);
    total++; if (got !== 16'h007F || lat != 2) begin bad++; $display("FAIL rst_pre got=%h lat=%0d want=007f lat=2", got, lat); end
    rd_valid = 1'b1; rd_addr = 4'd2;
    step();
    rd_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    total++; if (rd_data !== 16'd0 || rd_data_valid !== 1'b0 || lossy_cnt !== 16'(m_lossy)) begin bad++; $display("FAIL rst_async got=%h/%b/%h want=0000/0/0000", rd_data, rd_data_valid, lossy_cnt); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (rd_data_valid !== 1'b0 || rd_data !== 16'd0 || lossy_cnt !== 16'd0) begin bad++; $display("FAIL rst_after cyc=%0d got=%h/%b/%h want=0000/0/0000", i, rd_data, rd_data_valid, lossy_cnt); end
    end
    read_word(4'd2, got, lat);
    total++; if (got !== model_read(4'd2) || lat != 2) begin bad++; $display("FAIL rst_read got=%h lat=%0d want=0000 lat=2", got, lat); end
  endtask
  initial begin
    test_reset();
    test_trunc();
    test_narrow();
    test_same_cycle();
    test_back_to_back();
    test_clear();
    test_saturation();
    test_rst_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
